// File: rtl/vga_fb_fetch.sv
// vga_fb_fetch: framebuffer prefetcher for a VGA pipeline.
// Reads RGB332 bytes sequentially from memory into a small pixel FIFO and
// pops one pixel per pix_en strobe, expanding it to 8-bit-per-channel colour.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   frame_start         one-clk pulse at start of frame (restarts fetching)
//   pix_en              one-clk strobe per active pixel (pops the FIFO)
//   mem_req, mem_addr   read request / address to framebuffer memory
//   mem_ack, mem_rdata  request accepted, data valid in the same cycle
//   r, g, b             expanded pixel colour, registered
//   underflow           sticky: pix_en seen with an empty FIFO
//   fifo_level          current FIFO occupancy
module vga_fb_fetch #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned FB_BASE    = 0,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_W     = 19
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          frame_start,
    input  logic                          pix_en,
    output logic                          mem_req,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic                          mem_ack,
    input  logic [7:0]                    mem_rdata,
    output logic [7:0]                    r,
    output logic [7:0]                    g,
    output logic [7:0]                    b,
    output logic                          underflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned TOTAL = H_ACTIVE * V_ACTIVE;
    localparam int unsigned CNT_W = $clog2(TOTAL + 1);

    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(FB_BASE);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(TOTAL);
    localparam logic [LVL_W-1:0]  DEPTH_LVL = LVL_W'(FIFO_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] REQ   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              restart_q, restart_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              underflow_q, underflow_d;
    logic [7:0]        r_q, r_d, g_q, g_d, b_q, b_d;
    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [7:0]        pix;

    logic ack_hit, restart_now, flush, push, pop;

    always_comb begin
        ack_hit     = (state_q == REQ) && mem_ack;
        // A restart requested while a read is in flight completes on that read's ack;
        // the returned byte belongs to the old frame and is dropped.
        restart_now = ack_hit && (restart_q || frame_start);
        flush       = (frame_start && (state_q != REQ)) || restart_now;
        push        = ack_hit && !restart_now;
        // frame_start (and the flush it causes) takes priority over a pop.
        pop         = pix_en && !frame_start && !flush && (level_q != '0);

        underflow_d = underflow_q | (pix_en && (level_q == '0));

        level_d  = level_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            level_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      level_d = level_q + 1'b1;
            else if (pop && !push) level_d = level_q - 1'b1;
        end

        pix = fifo_mem[rd_ptr_q];
        r_d = 8'h00;
        g_d = 8'h00;
        b_d = 8'h00;
        if (pop) begin
            r_d = {pix[7:5], pix[7:5], pix[7:6]};
            g_d = {pix[4:2], pix[4:2], pix[4:3]};
            b_d = {4{pix[1:0]}};
        end

        cnt_inc   = cnt_q + 1'b1;
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        restart_d = restart_q;

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = FETCH;
                    addr_d  = BASE_ADDR;
                    cnt_d   = '0;
                end
            end
            FETCH: begin
                if (frame_start) begin
                    addr_d = BASE_ADDR;
                    cnt_d  = '0;
                end else if (level_q < DEPTH_LVL) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (restart_now) begin
                    state_d   = FETCH;
                    addr_d    = BASE_ADDR;
                    cnt_d     = '0;
                    restart_d = 1'b0;
                end else if (ack_hit) begin
                    addr_d = addr_q + 1'b1;
                    cnt_d  = cnt_inc;
                    if (cnt_inc == LAST_CNT)      state_d = DONE;
                    else if (level_d < DEPTH_LVL) state_d = REQ;
                    else                          state_d = FETCH;
                end else if (frame_start) begin
                    // Keep the request up; the address must not move until ack.
                    restart_d = 1'b1;
                end
            end
            DONE: begin
                if (frame_start) begin
                    state_d = FETCH;
                    addr_d  = BASE_ADDR;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= BASE_ADDR;
            cnt_q       <= '0;
            restart_q   <= 1'b0;
            level_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            underflow_q <= 1'b0;
            r_q         <= 8'h00;
            g_q         <= 8'h00;
            b_q         <= 8'h00;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            restart_q   <= restart_d;
            level_q     <= level_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            underflow_q <= underflow_d;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= mem_rdata;
    end

    assign mem_req    = (state_q == REQ);
    assign mem_addr   = addr_q;
    assign r          = r_q;
    assign g          = g_q;
    assign b          = b_q;
    assign underflow  = underflow_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_vga_fb_fetch.sv
module tb_vga_fb_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        frame_start, pix_en, mem_ack;
    logic        mem_req;
    logic [18:0] mem_addr;
    logic [7:0]  mem_rdata, r, g, b;
    logic        underflow;
    logic [4:0]  fifo_level;

    logic        s_frame_start, s_pix_en, s_mem_ack;
    logic        s_mem_req;
    logic [18:0] s_mem_addr;
    logic [7:0]  s_mem_rdata, s_r, s_g, s_b;
    logic        s_underflow;
    logic [4:0]  s_fifo_level;

    logic [7:0]  mem_img [256];

    int checks = 0;
    int errors = 0;

    assign mem_rdata   = mem_img[mem_addr[7:0]];
    assign s_mem_rdata = mem_img[s_mem_addr[7:0]];

    vga_fb_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .pix_en     (pix_en),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .r          (r),
        .g          (g),
        .b          (b),
        .underflow  (underflow),
        .fifo_level (fifo_level)
    );

    vga_fb_fetch #(
        .H_ACTIVE(4),
        .V_ACTIVE(2)
    ) dut_s (
        .clk        (clk),
        .rst        (rst),
        .frame_start(s_frame_start),
        .pix_en     (s_pix_en),
        .mem_req    (s_mem_req),
        .mem_addr   (s_mem_addr),
        .mem_ack    (s_mem_ack),
        .mem_rdata  (s_mem_rdata),
        .r          (s_r),
        .g          (s_g),
        .b          (s_b),
        .underflow  (s_underflow),
        .fifo_level (s_fifo_level)
    );

    // RGB332 -> 24-bit colour by bit replication.
    function automatic logic [23:0] expand(input logic [7:0] d);
        logic [7:0] rr, gg, bb;
        rr = {d[7:5], d[7:5], d[7:6]};
        gg = {d[4:2], d[4:2], d[4:3]};
        bb = {d[1:0], d[1:0], d[1:0], d[1:0]};
        return {rr, gg, bb};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        frame_start = 1'b0; pix_en = 1'b0; mem_ack = 1'b0;
        s_frame_start = 1'b0; s_pix_en = 1'b0; s_mem_ack = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", mem_req); end
        checks++; if (mem_addr !== 19'd0) begin errors++; $display("FAIL reset_addr: got %0h want 0", mem_addr); end
        checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        checks++; if ({r, g, b} !== 24'd0) begin errors++; $display("FAIL reset_rgb: got %h want 0", {r, g, b}); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_uf: got %b want 0", underflow); end
        @(negedge clk);
        step();
        rst = 1'b0;
        mem_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL idle_no_req: got %b want 0 cycle %0d", mem_req, i); end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_burst();
        int n;
        n = 0;
        mem_ack = 1'b1;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mem_req) begin
                checks++; if (mem_addr !== 19'(n)) begin errors++; $display("FAIL burst_addr: got %0d want %0d", mem_addr, n); end
                n++;
            end
            step();
        end
        checks++; if (n != 16) begin errors++; $display("FAIL burst_count: got %0d want 16", n); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL burst_req_end: got %b want 0", mem_req); end
        checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL burst_level: got %0d want 16", fifo_level); end
        mem_ack = 1'b0;
    endtask

    task automatic test_pop_colour();
        pix_en = 1'b1;
        step();
        pix_en = 1'b0;
        checks++; if ({r, g, b} !== 24'hFF0000) begin errors++; $display("FAIL pop_e0: got %h want ff0000", {r, g, b}); end
        checks++; if (fifo_level !== 5'd15) begin errors++; $display("FAIL pop_level: got %0d want 15", fifo_level); end
        step();
        checks++; if ({r, g, b} !== 24'd0) begin errors++; $display("FAIL blank_rgb: got %h want 0", {r, g, b}); end
        checks++; if (mem_req !== 1'b1 || mem_addr !== 19'd16) begin
            errors++; $display("FAIL refill_req: got req=%b addr=%0d want req=1 addr=16", mem_req, mem_addr); end
        pix_en = 1'b1;
        step();
        pix_en = 1'b0;
        checks++; if ({r, g, b} !== expand(mem_img[1])) begin errors++; $display("FAIL pop_second: got %h want %h", {r, g, b}, expand(mem_img[1])); end
        checks++; if (fifo_level !== 5'd14) begin errors++; $display("FAIL pop2_level: got %0d want 14", fifo_level); end
        checks++; if (mem_req !== 1'b1 || mem_addr !== 19'd16) begin
            errors++; $display("FAIL hold_addr: got req=%b addr=%0d want req=1 addr=16", mem_req, mem_addr); end
    endtask

    task automatic test_restart_pending();
        bit found;
        found = 1'b0;
        // First restart brings the fetcher back to address 0; then run up to address 5.
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (mem_req && mem_addr == 19'd5 && fifo_level == 5'd5) begin found = 1'b1; break; end
            mem_ack = 1'b1;
            step();
        end
        mem_ack = 1'b0;
        checks++; if (!found) begin errors++; $display("FAIL reach_addr5: got req=%b addr=%0d level=%0d want req at 5 level 5", mem_req, mem_addr, fifo_level); end
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (mem_req !== 1'b1 || mem_addr !== 19'd5) begin
                errors++; $display("FAIL pending_hold: got req=%b addr=%0d want req=1 addr=5", mem_req, mem_addr); end
            step();
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL restart_flush: got %0d want 0", fifo_level); end
        found = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (mem_req) begin found = 1'b1; break; end
            step();
        end
        checks++; if (!found || mem_addr !== 19'd0 || fifo_level !== 5'd0) begin
            errors++; $display("FAIL restart_req0: got req=%b addr=%0d level=%0d want req=1 addr=0 level=0", mem_req, mem_addr, fifo_level); end
    endtask

    task automatic test_underflow();
        pix_en = 1'b1;
        step();
        pix_en = 1'b0;
        checks++; if ({r, g, b} !== 24'd0) begin errors++; $display("FAIL uf_rgb: got %h want 0", {r, g, b}); end
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_set: got %b want 1", underflow); end
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        step();
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %b want 1", underflow); end
    endtask

    task automatic test_random_stream();
        logic [7:0]  q[$];
        logic [23:0] exp_rgb;
        logic        exp_uf, prev_stall;
        logic [18:0] prev_addr;
        int          exp_addr, reads;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL rst_clears_uf: got %b want 0", underflow); end
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        exp_uf = 1'b0; exp_addr = 0; reads = 0; prev_stall = 1'b0; prev_addr = '0;
        for (int i = 0; i < 800; i++) begin
            if (prev_stall) begin
                checks++; if (mem_req !== 1'b1 || mem_addr !== prev_addr) begin
                    errors++; $display("FAIL rnd_stable: got req=%b addr=%0d want req=1 addr=%0d", mem_req, mem_addr, prev_addr); end
            end
            if (mem_req) begin
                checks++; if (fifo_level >= 5'd16) begin errors++; $display("FAIL rnd_req_full: got level %0d want <16", fifo_level); end
            end
            pix_en  = ($urandom_range(99) < 40);
            mem_ack = $urandom_range(1) == 1;
            // Pop sees the occupancy before this edge's push.
            exp_rgb = 24'd0;
            if (pix_en) begin
                if (q.size() > 0) exp_rgb = expand(q.pop_front());
                else              exp_uf  = 1'b1;
            end
            if (mem_req && mem_ack) begin
                checks++; if (mem_addr !== 19'(exp_addr)) begin errors++; $display("FAIL rnd_addr: got %0d want %0d", mem_addr, exp_addr); end
                q.push_back(mem_img[exp_addr[7:0]]);
                exp_addr++;
                reads++;
            end
            prev_stall = mem_req && !mem_ack;
            prev_addr  = mem_addr;
            step();
            checks++; if ({r, g, b} !== exp_rgb) begin errors++; $display("FAIL rnd_rgb: got %h want %h cycle %0d", {r, g, b}, exp_rgb, i); end
            checks++; if (int'(fifo_level) != q.size()) begin errors++; $display("FAIL rnd_level: got %0d want %0d cycle %0d", fifo_level, q.size(), i); end
            checks++; if (underflow !== exp_uf) begin errors++; $display("FAIL rnd_uf: got %b want %b cycle %0d", underflow, exp_uf, i); end
        end
        pix_en = 1'b0; mem_ack = 1'b0;
        checks++; if (reads < 100) begin errors++; $display("FAIL rnd_reads: got %0d want >=100", reads); end
    endtask

    task automatic test_reset_mid();
        int n;
        rst = 1'b1;
        step();
        rst = 1'b0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        n = 0;
        for (int i = 0; i < 50 && n < 10; i++) begin
            mem_ack = 1'b1;
            if (mem_req) n++;
            step();
        end
        mem_ack = 1'b0;
        pix_en = 1'b1;
        step();
        pix_en = 1'b0;
        checks++; if (mem_req !== 1'b1 || fifo_level !== 5'd9 || {r, g, b} !== 24'hFF0000) begin
            errors++; $display("FAIL pre_rst: got req=%b level=%0d rgb=%h want req=1 level=9 rgb=ff0000", mem_req, fifo_level, {r, g, b}); end
        #2 rst = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL async_req: got %b want 0", mem_req); end
        checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL async_level: got %0d want 0", fifo_level); end
        checks++; if ({r, g, b} !== 24'd0) begin errors++; $display("FAIL async_rgb: got %h want 0", {r, g, b}); end
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (mem_req !== 1'b0 || fifo_level !== 5'd0) begin
                errors++; $display("FAIL post_rst_ack: got req=%b level=%0d want 0 0", mem_req, fifo_level); end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_small_frame();
        int  n;
        bit  found;
        n = 0;
        s_mem_ack = 1'b1;
        s_frame_start = 1'b1;
        step();
        s_frame_start = 1'b0;
        s_pix_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (s_mem_req) begin
                checks++; if (s_mem_addr !== 19'(n)) begin errors++; $display("FAIL small_addr: got %0d want %0d", s_mem_addr, n); end
                n++;
            end
            step();
        end
        checks++; if (n != 8) begin errors++; $display("FAIL small_count: got %0d want 8", n); end
        checks++; if (s_mem_req !== 1'b0 || s_fifo_level !== 5'd0) begin
            errors++; $display("FAIL small_done: got req=%b level=%0d want 0 0", s_mem_req, s_fifo_level); end
        checks++; if (s_underflow !== 1'b1 || {s_r, s_g, s_b} !== 24'd0) begin
            errors++; $display("FAIL small_drained: got uf=%b rgb=%h want uf=1 rgb=0", s_underflow, {s_r, s_g, s_b}); end
        s_pix_en = 1'b0;
        s_frame_start = 1'b1;
        step();
        s_frame_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (s_mem_req) begin found = 1'b1; break; end
            step();
        end
        checks++; if (!found || s_mem_addr !== 19'd0) begin
            errors++; $display("FAIL small_restart: got req=%b addr=%0d want req=1 addr=0", s_mem_req, s_mem_addr); end
        s_mem_ack = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_img[i] = 8'($urandom);
        mem_img[0] = 8'hE0;
        test_reset();
        test_burst();
        test_pop_colour();
        test_restart_pending();
        test_underflow();
        test_random_stream();
        test_reset_mid();
        test_small_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_fb_fetch.md
VGA_FB_FETCH -- requirements
Module: vga_fb_fetch

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, active lines per frame.
REQ-003 SHALL have parameter FB_BASE, default 0, framebuffer byte address of pixel (0,0).
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, pixel FIFO entries (power of two).
REQ-005 SHALL have parameter ADDR_W, default 19, memory address width.
REQ-006 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port frame_start  input  1  one-clk pulse from the timing stage at start of frame.
REQ-009 SHALL have port pix_en  input  1  one-clk strobe from the timing stage per active pixel.
REQ-010 SHALL have port mem_req  output  1  framebuffer read request.
REQ-011 SHALL have port mem_addr  output  ADDR_W  read address.
REQ-012 SHALL have port mem_ack  input  1  request accepted; mem_rdata valid the same cycle.
REQ-013 SHALL have port mem_rdata  input  8  pixel byte, RGB332 (R[7:5], G[4:2], B[1:0]).
REQ-014 SHALL have ports r, g, b  output  8 each  pixel colour to the sync/output stage.
REQ-015 SHALL have port underflow  output  1  sticky flag: pix_en seen with FIFO empty.
REQ-016 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, REQ, DONE.
REQ-018 IDLE -> FETCH on frame_start: FIFO flushed to level 0, address = FB_BASE, pixel count = 0.
REQ-019 FETCH -> REQ when FIFO level < FIFO_DEPTH; stay in FETCH otherwise.
REQ-020 mem_req SHALL be 1 exactly in REQ; mem_addr SHALL be stable while mem_req=1 and not mem_ack.
REQ-021 On mem_ack in REQ: push mem_rdata, address+1, count+1; at most one request outstanding.
REQ-022 On mem_ack, SHALL stay in REQ (back-to-back) if post-push level < FIFO_DEPTH and count+1 < H_ACTIVE*V_ACTIVE; else FETCH, or DONE when count+1 = H_ACTIVE*V_ACTIVE.
REQ-023 DONE SHALL issue no requests; DONE -> FETCH restart on frame_start (flush, address = FB_BASE).
REQ-024 frame_start in REQ SHALL not drop mem_req: pending-restart flag set, acked byte discarded, then FETCH with flush and address = FB_BASE.
REQ-025 pix_en with FIFO non-empty SHALL pop one entry; r,g,b registered one clk later.
REQ-026 Colour expansion: r={d[7:5],d[7:5],d[7:6]}, g={d[4:2],d[4:2],d[4:3]}, b={d[1:0] repeated 4x}.
REQ-027 r,g,b SHALL be 0 in any cycle following a clk without a successful pop (blanking, underflow).
REQ-028 pix_en with FIFO empty SHALL not pop, SHALL set underflow; underflow cleared only by rst.
REQ-029 Simultaneous push and pop SHALL leave level unchanged; push when full SHALL not occur by construction.
REQ-030 frame_start and pix_en in the same clk: frame_start wins, no pop, next r,g,b = 0.
REQ-031 Address arithmetic SHALL wrap modulo 2^ADDR_W.

Reset
REQ-032 rst=1 SHALL immediately force: state IDLE, mem_req 0, mem_addr FB_BASE, FIFO level 0, r=g=b=0, underflow 0, restart flag 0.
REQ-033 After rst deassert, no request SHALL issue before the first frame_start.
REQ-034 rst asserted mid-REQ SHALL abort the transaction; a later mem_ack in IDLE SHALL be ignored.

Verification
REQ-035 frame_start, mem_ack tied 1, no pix_en -> 16 back-to-back reads addr 0..15, then mem_req 0, fifo_level 16.
REQ-036 Memory returns 8'hE0 at addr 0, one pix_en -> next clk r=8'hFF, g=0, b=0; fifo_level decrements.
REQ-037 pix_en with empty FIFO -> r=g=b=0, underflow=1 and stays 1 across the next frame_start.
REQ-038 H_ACTIVE=4, V_ACTIVE=2, continuous pops -> exactly 8 reads, addr 0..7, state DONE, mem_req 0.
REQ-039 frame_start while mem_req=1 at addr 5, ack delayed 3 clk -> req/addr held, data discarded, next req addr 0, level 0.
REQ-040 rst asserted with mem_req=1 and level 9 -> same-cycle mem_req 0, level 0, r=g=b=0.
